apb_slave_mem: RTL and testbench

APB completer that sits directly downstream of the team's APB master and answers its `pselx`/`penable` transfers with a word-addressed register memory. It inserts a programmable number of wait states, flags out-of-range or misaligned accesses on `pslverr`, and gives the master bench and integration a real, protocol-checking target.

---
 rtl/apb_slave_mem.sv | 200 ++++++++++++++++++++
 tb/tb_apb_slave_mem.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB completer backed by a word-addressed register memory. It answers the
// master's pselx/penable transfers, can insert a fixed number of wait states,
// and reports misaligned or out-of-range accesses on pslverr.
//
// Build option:
//   APB_SLAVE_WAIT_EN  defined   -> WAIT_CYCLES wait states per access
//                      undefined -> WAIT_CYCLES ignored, every access zero-wait
//                                   (no WAIT state, no counter)
//
// Parameters:
//   ADDR_WIDTH  width of paddr
//   DATA_WIDTH  width of pwdata/prdata (32 only; byte offset is paddr[1:0])
//   DEPTH       number of words, power of 2 in 2..256
//   WAIT_CYCLES wait states per access, 0..15
//
// Ports:
//   pclk     in   clock, rising edge
//   presetn  in   asynchronous active-low reset
//   pselx    in   select
//   penable  in   access-phase strobe
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address
//   pwdata   in   write data
//   prdata   out  read data (registered)
//   pready   out  transfer complete (registered)
//   pslverr  out  error response, valid while pready=1 (registered)
// -----------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd2;
`ifdef APB_SLAVE_WAIT_EN
  localparam logic [1:0] ST_WAIT  = 2'd1;
`endif

  // Reject parameter sets the address decode cannot represent.
  if (DATA_WIDTH != 32 || DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
      WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || ADDR_WIDTH < IDX_W + 2) begin : g_bad_cfg
    $error("apb_slave_mem: unsupported parameter set");
  end

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic                  r_err;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;
`ifdef APB_SLAVE_WAIT_EN
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] w_rd_lat;
`endif

  logic                  w_setup;
  logic                  w_access;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_now;

  // Decode the current bus phase and the read data to present in READY.
  always_comb begin
    w_setup  = pselx && !penable;
    w_access = pselx && penable;
    w_idx    = paddr[2 +: IDX_W];
    // Any address bit above the word index set means beyond DEPTH words.
    w_err    = (paddr[1:0] != 2'b00) ||
               ((paddr >> (IDX_W + 2)) != {ADDR_WIDTH{1'b0}});
    // Zero-wait path loads straight from the setup-phase address.
    if (!pwrite && !w_err) begin
      w_rd_now = r_mem[w_idx];
    end else begin
      w_rd_now = {DATA_WIDTH{1'b0}};
    end
`ifdef APB_SLAVE_WAIT_EN
    // Wait path loads from the attributes latched at setup.
    if (!r_write && !r_err) begin
      w_rd_lat = r_mem[r_idx];
    end else begin
      w_rd_lat = {DATA_WIDTH{1'b0}};
    end
`endif
  end

  // Transfer FSM, latched attributes, registered response and word memory.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= ST_IDLE;
      r_idx     <= {IDX_W{1'b0}};
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= {DATA_WIDTH{1'b0}};
`ifdef APB_SLAVE_WAIT_EN
      r_cnt     <= 4'd0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_setup) begin
      // A setup phase always starts a fresh transfer, whatever the state.
      r_idx   <= w_idx;
      r_write <= pwrite;
      r_err   <= w_err;
`ifdef APB_SLAVE_WAIT_EN
      if (WAIT_CYCLES == 0) begin
        r_state   <= ST_READY;
        r_pready  <= 1'b1;
        r_pslverr <= w_err;
        r_prdata  <= w_rd_now;
      end else begin
        r_state   <= ST_WAIT;
        r_cnt     <= 4'(WAIT_CYCLES);
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
        r_prdata  <= {DATA_WIDTH{1'b0}};
      end
`else
      r_state   <= ST_READY;
      r_pready  <= 1'b1;
      r_pslverr <= w_err;
      r_prdata  <= w_rd_now;
`endif
    end else begin
      case (r_state)
`ifdef APB_SLAVE_WAIT_EN
        ST_WAIT: begin
          if (w_access) begin
            r_cnt <= r_cnt - 4'd1;
            // Counter at 1 here means the next cycle is the pready cycle.
            if (r_cnt == 4'd1) begin
              r_state   <= ST_READY;
              r_pready  <= 1'b1;
              r_pslverr <= r_err;
              r_prdata  <= w_rd_lat;
            end else begin
              r_state <= ST_WAIT;
            end
          end else begin
            // pselx dropped: abandon without touching memory.
            r_state   <= ST_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= {DATA_WIDTH{1'b0}};
          end
        end
`endif
        ST_READY: begin
          if (w_access) begin
            if (r_write && !r_err) begin
              r_mem[r_idx] <= pwdata;
            end else begin
              r_mem[r_idx] <= r_mem[r_idx];
            end
          end else begin
            r_mem[r_idx] <= r_mem[r_idx];
          end
          // Completion and abort both return to IDLE with outputs cleared.
          r_state   <= ST_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= {DATA_WIDTH{1'b0}};
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Directed bench for apb_slave_mem (DEPTH=16, WAIT_CYCLES=2). Expected access
// latency follows the APB_SLAVE_WAIT_EN build option: pready in T3 when
// enabled, T1 otherwise.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

  localparam int MAX_WAIT = 40;
`ifdef APB_SLAVE_WAIT_EN
  localparam int   EXP_LAT      = 3;
  localparam logic ABORT_T1_RDY = 1'b0;
`else
  localparam int   EXP_LAT      = 1;
  localparam logic ABORT_T1_RDY = 1'b1;
`endif

  logic        pclk;
  logic        presetn;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks;
  int failures;

  apb_slave_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .WAIT_CYCLES(2)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .pselx  (pselx),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // One APB transfer; caller is 1ns after a rising edge, returns likewise.
  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic early, output logic setup_rdy);
    pselx = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge pclk);
    setup_rdy = pready;
    @(posedge pclk); #1;
    penable = 1'b1;
    lat = 0; rd = 32'h0; er = 1'b0; early = 1'b0;
    for (int k = 1; k <= MAX_WAIT && lat == 0; k++) begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        lat = k; rd = prdata; er = pslverr;
      end else if (prdata !== 32'h0 || pslverr !== 1'b0) begin
        early = 1'b1;
      end
      @(posedge pclk); #1;
    end
    pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic er, early, sr;
    @(negedge pclk);
    checks++;
    if ({pready, pslverr, prdata} !== 34'h0) begin
      failures++; $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h, want all 0", pready, pslverr, prdata);
    end
    @(posedge pclk); #1; presetn = 1'b1;
    @(posedge pclk); #1;
    apb_xfer(1'b0, 32'h08, 32'h0, lat, rd, er, early, sr);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("FAIL reset_mem_zero: got %h, want 00000000", rd);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er, early, sr;
    apb_xfer(1'b1, 32'h08, 32'hDEADBEEF, lat, rd, er, early, sr);
    checks++;
    if (lat !== EXP_LAT || er !== 1'b0) begin
      failures++; $display("FAIL wr08_resp: got lat=%0d err=%b, want lat=%0d err=0", lat, er, EXP_LAT);
    end
    apb_xfer(1'b0, 32'h08, 32'h0, lat, rd, er, early, sr);
    checks++;
    if (lat !== EXP_LAT) begin
      failures++; $display("FAIL rd08_lat: got %0d, want %0d", lat, EXP_LAT);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++; $display("FAIL rd08_data: got %h err=%b, want deadbeef err=0", rd, er);
    end
    @(negedge pclk);
    checks++;
    if (pready !== 1'b0 || prdata !== 32'h0) begin
      failures++; $display("FAIL idle_clear: got rdy=%b rd=%h, want 0/00000000", pready, prdata);
    end
    @(posedge pclk); #1;
  endtask

  task automatic test_wait_read();
    int lat; logic [31:0] rd; logic er, early, sr;
    apb_xfer(1'b1, 32'h04, 32'h12345678, lat, rd, er, early, sr);
    apb_xfer(1'b0, 32'h04, 32'h0, lat, rd, er, early, sr);
    checks++;
    if (lat !== EXP_LAT) begin
      failures++; $display("FAIL wait_lat: pready in T%0d, want T%0d", lat, EXP_LAT);
    end
    checks++;
    if (early !== 1'b0) begin
      failures++; $display("FAIL wait_early: got early data/err=%b, want 0", early);
    end
    checks++;
    if (rd !== 32'h12345678) begin
      failures++; $display("FAIL wait_data: got %h, want 12345678", rd);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er, early, sr;
    apb_xfer(1'b1, 32'h00, 32'hA5A5A5A5, lat, rd, er, early, sr);
    apb_xfer(1'b1, 32'h40, 32'hFFFF0000, lat, rd, er, early, sr);
    checks++;
    if (er !== 1'b1 || lat !== EXP_LAT) begin
      failures++; $display("FAIL oor_err: got err=%b lat=%0d, want err=1 lat=%0d", er, lat, EXP_LAT);
    end
    apb_xfer(1'b0, 32'h00, 32'h0, lat, rd, er, early, sr);
    checks++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      failures++; $display("FAIL oor_alias: got %h err=%b, want a5a5a5a5 err=0", rd, er);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic er, early, sr;
    apb_xfer(1'b0, 32'h06, 32'h0, lat, rd, er, early, sr);
    checks++;
    if (er !== 1'b1) begin
      failures++; $display("FAIL mis_err: got %b, want 1", er);
    end
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("FAIL mis_data: got %h, want 00000000", rd);
    end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic er, early, sr;
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hCAFEF00D;
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    @(negedge pclk);
    checks++;
    if (pready !== ABORT_T1_RDY) begin
      failures++; $display("FAIL abort_t1: got rdy=%b, want %b", pready, ABORT_T1_RDY);
    end
    @(posedge pclk); #1;
    @(negedge pclk);
    checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0) begin
      failures++; $display("FAIL abort_idle: got rdy=%b err=%b, want 0/0", pready, pslverr);
    end
    @(posedge pclk); #1;
    pwrite = 1'b0;
    apb_xfer(1'b0, 32'h0C, 32'h0, lat, rd, er, early, sr);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("FAIL abort_nowrite: got %h, want 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er, early, sr;
    logic [31:0] addrs [3];
    addrs[0] = 32'h08; addrs[1] = 32'h04; addrs[2] = 32'h10;
    // Reset in the first access cycle of a write to 0x10.
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h5555AAAA;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    checks++;
    if ({pready, pslverr, prdata} !== 34'h0) begin
      failures++; $display("FAIL rst_mid: got rdy=%b err=%b rd=%h, want all 0", pready, pslverr, prdata);
    end
    pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    for (int j = 0; j < 3; j++) begin
      apb_xfer(1'b0, addrs[j], 32'h0, lat, rd, er, early, sr);
      checks++;
      if (rd !== 32'h0) begin
        failures++; $display("FAIL rst_mem%0d: addr %h got %h, want 00000000", j, addrs[j], rd);
      end
    end
    apb_xfer(1'b1, 32'h10, 32'h0BADF00D, lat, rd, er, early, sr);
    apb_xfer(1'b0, 32'h10, 32'h0, lat, rd, er, early, sr);
    checks++;
    if (sr !== 1'b0) begin
      failures++; $display("FAIL b2b_setup_rdy: got %b, want 0", sr);
    end
    checks++;
    if (rd !== 32'h0BADF00D || lat !== EXP_LAT) begin
      failures++; $display("FAIL b2b_read: got %h lat=%0d, want 0badf00d lat=%0d", rd, lat, EXP_LAT);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    presetn = 1'b0; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    repeat (2) @(posedge pclk);
    #1;
    test_reset();
    test_write_read();
    test_wait_read();
    test_out_of_range();
    test_misaligned();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
